// File: rtl/mem_access_seq.sv
// Memory access sequencer: turns one-shot read/write requests from the data path into
// fixed-length memory strobe sequences, closing each transaction with a one-cycle READY/ERR pulse.
module mem_access_seq #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [25:0] ADDR_LIMIT  = 26'h3FFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_read,
  input  logic        i_req_write,
  input  logic [25:0] i_addr,
  input  logic [31:0] i_dp_wdata,
  output logic [31:0] o_dp_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err,
  output logic [25:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mem_read,
  output logic        o_mem_write
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_read;
  logic [25:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_dp_rdata;
  logic        r_ready;
  logic        r_busy;
  logic        r_err;
  logic        r_mem_read;
  logic        r_mem_write;

  state_t      w_state;
  logic [3:0]  w_cnt;
  logic        w_is_read;
  logic [25:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [31:0] w_dp_rdata;
  logic        w_ready;
  logic        w_busy;
  logic        w_err;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_one_req;
  logic        w_both_req;
  logic        w_addr_bad;

  assign w_one_req  = i_req_read ^ i_req_write;
  assign w_both_req = i_req_read & i_req_write;
  assign w_addr_bad = (i_addr > ADDR_LIMIT);

  // State register and every output register; reset drops strobes immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_is_read   <= 1'b0;
      r_mem_addr  <= 26'd0;
      r_mem_wdata <= 32'd0;
      r_dp_rdata  <= 32'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_is_read   <= w_is_read;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_dp_rdata  <= w_dp_rdata;
      r_ready     <= w_ready;
      r_busy      <= w_busy;
      r_err       <= w_err;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
    end
  end

  // Next-state and next-output logic; READY/ERR are pulses so they default low.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_is_read   = r_is_read;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_dp_rdata  = r_dp_rdata;
    w_ready     = 1'b0;
    w_err       = 1'b0;
    w_mem_read  = r_mem_read;
    w_mem_write = r_mem_write;

    case (r_state)
      ST_IDLE: begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        if (w_both_req) begin
          w_err = 1'b1;
        end else if (w_one_req) begin
          if (w_addr_bad) begin
            // Out-of-range address: skip memory, complete with READY+ERR.
            w_state = ST_DONE;
            w_ready = 1'b1;
            w_err   = 1'b1;
            if (i_req_read) begin
              w_dp_rdata = 32'd0;
            end else begin
              w_dp_rdata = r_dp_rdata;
            end
          end else begin
            w_state     = ST_ACCESS;
            w_cnt       = LP_WAIT;
            w_is_read   = i_req_read;
            w_mem_addr  = i_addr;
            w_mem_wdata = i_dp_wdata;
            w_mem_read  = i_req_read;
            w_mem_write = i_req_write;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_state     = ST_DONE;
          w_ready     = 1'b1;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          if (r_is_read) begin
            w_dp_rdata = i_mem_rdata;
          end else begin
            w_dp_rdata = r_dp_rdata;
          end
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end

      ST_DONE: begin
        w_state     = ST_IDLE;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
      end

      default: begin
        w_state     = ST_IDLE;
        w_cnt       = 4'd0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  assign o_dp_rdata  = r_dp_rdata;
  assign o_ready     = r_ready;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: a request-level reference model queues expected
// completions; a negedge monitor emulates memory and checks each READY/ERR against the queue.
module tb_mem_access_seq;

  localparam int          W     = 2;
  localparam logic [25:0] LIMIT = 26'h00000FF;

  typedef struct {
    bit          ready;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
    int          slen;
    bit          is_wr;
    logic [25:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_read;
  logic        req_write;
  logic [25:0] addr;
  logic [31:0] dp_wdata;
  logic [31:0] dp_rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  exp_t        sb_q[$];
  logic [31:0] ref_mem  [0:255];
  logic [31:0] phys_mem [0:255];
  logic [31:0] last_rd;
  int          cyc;
  int          n_vec;
  int          n_miss;

  mem_access_seq #(.WAIT_CYCLES(W), .ADDR_LIMIT(LIMIT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_read  (req_read),
    .i_req_write (req_write),
    .i_addr      (addr),
    .i_dp_wdata  (dp_wdata),
    .o_dp_rdata  (dp_rdata),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_err       (err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outcome of one request from the request-level rules alone.
  task automatic model(input bit rd, input bit wr, input logic [25:0] a, input logic [31:0] d,
                       input int k, output exp_t e);
    e.ready = 1'b0;
    e.err   = 1'b0;
    e.cyc   = k;
    e.slen  = 0;
    e.is_wr = wr;
    e.addr  = a;
    e.wdata = d;
    if (rd && wr) begin
      e.err = 1'b1;
    end else if (a > LIMIT) begin
      e.ready = 1'b1;
      e.err   = 1'b1;
      if (rd) last_rd = 32'd0;
    end else begin
      e.ready = 1'b1;
      e.cyc   = k + W + 1;
      e.slen  = W + 1;
      if (wr) ref_mem[a[7:0]] = d;
      else    last_rd = ref_mem[a[7:0]];
    end
    e.rdata = last_rd;
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic issue(input bit rd, input bit wr, input logic [25:0] a, input logic [31:0] d,
                       input bit noise, input int n_txn);
    exp_t e;
    int   k;
    int   seen;
    int   budget;
    req_read  = rd;
    req_write = wr;
    addr      = a;
    dp_wdata  = d;
    k = cyc + 1;
    for (int t = 0; t < n_txn; t++) begin
      model(rd, wr, a, d, k + t * (W + 3), e);
      sb_q.push_back(e);
    end
    seen   = 0;
    budget = 0;
    while (seen < n_txn) begin
      @(negedge clk);
      budget++;
      if (ready || err) begin
        seen++;
        if (seen == n_txn) begin
          req_read  = 1'b0;
          req_write = 1'b0;
        end
      end else if (noise && busy) begin
        req_read  = 1'($urandom_range(1, 0));
        req_write = 1'($urandom_range(1, 0));
        addr      = 26'($urandom);
        dp_wdata  = $urandom;
      end
      if (budget > 100) begin
        check("done_timeout", 32'(seen), 32'(n_txn));
        seen      = n_txn;
        req_read  = 1'b0;
        req_write = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Monitor and memory emulation: read data is only valid on the final strobe cycle.
  initial begin
    int          s_len;
    bit          s_wr;
    bit          s_bad;
    logic [25:0] s_addr;
    logic [31:0] s_wdata;
    exp_t        e;
    s_len = 0;
    s_bad = 1'b0;
    s_wr  = 1'b0;
    s_addr = 26'd0;
    s_wdata = 32'd0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_len     = 0;
        s_bad     = 1'b0;
        mem_rdata = 32'd0;
      end else begin
        mem_rdata = $urandom;
        if (mem_read || mem_write) begin
          check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
          s_len++;
          if (s_len == 1) begin
            s_wr    = mem_write;
            s_addr  = mem_addr;
            s_wdata = mem_wdata;
          end else if (mem_addr !== s_addr || mem_write !== s_wr ||
                       (mem_write && mem_wdata !== s_wdata)) begin
            s_bad = 1'b1;
          end
          if (mem_write) phys_mem[mem_addr[7:0]] = mem_wdata;
          if (mem_read && s_len == W + 1) mem_rdata = phys_mem[mem_addr[7:0]];
        end
        if (ready || err) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("ready",    32'(ready),    32'(e.ready));
            check("err",      32'(err),      32'(e.err));
            check("busy",     32'(busy),     32'(e.ready));
            check("dp_rdata", dp_rdata,      e.rdata);
            check("latency",  32'(cyc),      32'(e.cyc));
            check("strobe_len", 32'(s_len),  32'(e.slen));
            if (e.slen > 0) begin
              check("strobe_dir",  32'(s_wr),  32'(e.is_wr));
              check("mem_addr",    32'(s_addr), 32'(e.addr));
              check("strobe_stable", 32'(s_bad), 32'd0);
              if (e.is_wr) check("mem_wdata", s_wdata, e.wdata);
            end
          end
          s_len = 0;
          s_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [25:0] ra;
    logic [31:0] rd_v;
    int          kind;
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    addr      = 26'd0;
    dp_wdata  = 32'd0;
    last_rd   = 32'd0;
    for (int i = 0; i < 256; i++) begin
      rd_v = $urandom;
      ref_mem[i]  = rd_v;
      phys_mem[i] = rd_v;
    end

    @(negedge clk);
    check("rst_dp_rdata", dp_rdata, 32'd0);
    check("rst_ready",    32'(ready), 32'd0);
    check("rst_busy",     32'(busy),  32'd0);
    check("rst_err",      32'(err),   32'd0);
    check("rst_strobes",  32'({mem_read, mem_write}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    ref_mem[8'h10]  = 32'hDEADBEEF;
    phys_mem[8'h10] = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 26'h0000010, 32'h0, 1'b0, 1);
    check("read_deadbeef", dp_rdata, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 26'h0000020, 32'h12345678, 1'b0, 1);
    check("write_mem", phys_mem[8'h20], 32'h12345678);
    check("write_keeps_rdata", dp_rdata, 32'hDEADBEEF);

    // Reset in the middle of a read access.
    req_read = 1'b1;
    addr     = 26'h0000030;
    @(negedge clk);
    req_read = 1'b0;
    @(negedge clk);
    check("pre_rst_strobe", 32'(mem_read), 32'd1);
    #3;
    rst_n   = 1'b0;
    last_rd = 32'd0;
    #1;
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_ready",    32'(ready),    32'd0);
    check("midrst_dp_rdata", dp_rdata,      32'd0);
    @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", 32'(ready), 32'd0);

    issue(1'b1, 1'b1, 26'h0000040, 32'hA5A5A5A5, 1'b0, 1);
    issue(1'b1, 1'b0, 26'h0000010, 32'h0, 1'b0, 1);
    issue(1'b1, 1'b0, 26'h0000100, 32'h0, 1'b0, 1);
    check("addr_err_rdata", dp_rdata, 32'd0);
    issue(1'b1, 1'b0, 26'h0000010, 32'h0, 1'b0, 2);
    issue(1'b0, 1'b1, 26'h0000200, 32'h55AA55AA, 1'b0, 1);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(99, 0);
      ra   = 26'($urandom_range(319, 0));
      rd_v = $urandom;
      if (kind < 45)      issue(1'b1, 1'b0, ra, rd_v, 1'b1, 1);
      else if (kind < 90) issue(1'b0, 1'b1, ra, rd_v, 1'b1, 1);
      else if (kind < 95) issue(1'b1, 1'b1, ra, rd_v, 1'b0, 1);
      else                issue(1'b1, 1'b0, ra, rd_v, 1'b0, 2);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
